// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and the future TX path).
//   PAR_*      : parity mode constants for the PARITY parameter
//   rx_state_e : receiver FSM states
//   maj3       : 3-sample majority vote used for every bit decision
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read/status port of the UART receiver.
//   master : core side, drives rd_en / clr_err, sees head data and status
//   slave  : receiver side
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) ();
  logic                          rd_en;
  logic                          clr_err;
  logic [DATA_BITS-1:0]          rd_data;
  logic                          empty;
  logic                          full;
  logic [$clog2(FIFO_DEPTH):0]   count;
  logic                          frame_err;
  logic                          parity_err;
  logic                          overrun;

  modport master (output rd_en, clr_err,
                  input  rd_data, empty, full, count, frame_err, parity_err, overrun);
  modport slave  (input  rd_en, clr_err,
                  output rd_data, empty, full, count, frame_err, parity_err, overrun);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   push/wdata : write; accepted when not full, or when full with a same-cycle pop
//   pop        : remove head; ignored when empty
//   rdata      : current head (0 while empty); count/full/empty status
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // Pop frees a slot first, so a push while full with a pop still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with receive FIFO.
//   clk, rst (async, active-low), uart_rx (async serial line, idle high)
//   bus : read port / sticky error flags (uart_rx_fifo_if.slave)
// Each bit is the majority of three samples around mid-bit; the decision
// is taken one cycle after the bit centre. STOP leaves at the decision
// point so back-to-back frames are not missed.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_rx,
  uart_rx_fifo_if.slave   bus
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);

  rx_state_e            state, nxt;
  logic                 s1, rxs;
  logic [CW-1:0]        cnt;
  logic [2:0]           bitn;
  logic                 smp0, smp1, vote, dec, wrap;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, exp_par;
  logic                 push, ferr_ev, perr_ev, ovr_ev;

  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, rxs} <= 2'b11;
    else      {s1, rxs} <= {uart_rx, s1};

  assign vote    = maj3(smp0, smp1, rxs);
  assign dec     = (cnt == CW'(HALF + 1));
  assign wrap    = (cnt == CW'(CLK_DIV - 1));
  assign exp_par = (^shreg) ^ (PARITY == PAR_ODD);
  // FIFO is full so !empty: a same-cycle read makes room.
  assign ovr_ev  = push & bus.full & ~bus.rd_en;

  always_comb begin
    nxt     = state;
    push    = 1'b0;
    ferr_ev = 1'b0;
    perr_ev = 1'b0;
    case (state)
      S_IDLE:   if (!rxs) nxt = S_START;
      S_START:  if (dec && vote) nxt = S_IDLE;
                else if (wrap)   nxt = S_DATA;
      S_DATA:   if (wrap && bitn == 3'(DATA_BITS - 1))
                  nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) nxt = S_STOP;
      S_STOP:   if (dec) begin
                  if (!vote) begin
                    ferr_ev = 1'b1;
                    nxt     = S_BREAK;
                  end else if (par_bad) begin
                    perr_ev = 1'b1;
                    nxt     = S_IDLE;
                  end else begin
                    push    = 1'b1;
                    nxt     = S_IDLE;
                  end
                end
      S_BREAK:  if (rxs) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bitn    <= '0;
      smp0    <= 1'b1;
      smp1    <= 1'b1;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      state <= nxt;
      // cnt tracks cycles since the start edge; held at 0 while idle.
      if (nxt == S_IDLE) cnt <= '0;
      else               cnt <= wrap ? '0 : cnt + 1'b1;
      if (cnt == CW'(HALF - 1)) smp0 <= rxs;
      if (cnt == CW'(HALF))     smp1 <= rxs;
      if (state == S_IDLE) begin
        bitn    <= '0;
        par_bad <= 1'b0;
      end
      if (state == S_DATA) begin
        if (dec)  shreg <= {vote, shreg[DATA_BITS-1:1]};
        if (wrap) bitn  <= bitn + 1'b1;
      end
      if (state == S_PARITY && dec) par_bad <= (vote != exp_par);
    end
  end

  // Event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_err  <= (bus.frame_err  & ~bus.clr_err) | ferr_ev;
      bus.parity_err <= (bus.parity_err & ~bus.clr_err) | perr_ev;
      bus.overrun    <= (bus.overrun    & ~bus.clr_err) | ovr_ev;
    end
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shreg),
    .pop   (bus.rd_en),
    .rdata (bus.rd_data),
    .count (bus.count),
    .full  (bus.full),
    .empty (bus.empty)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: u0 is 8N1 with a 4-deep FIFO, u1 is 8E1.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx0 = 1'b1;
  logic rx1 = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) b0 ();
  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(8)) b1 ();

  uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .uart_rx(rx0), .bus(b0.slave));
  uart_rx_fifo #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(8)) u1 (
    .clk(clk), .rst(rst), .uart_rx(rx1), .bus(b1.slave));

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    int         push;
    logic       perr;
    logic       ferr;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drv(input int sel, input logic v);
    if (sel == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic bit_time(input int sel, input logic v);
    drv(sel, v);
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input int sel, input logic [7:0] d, input logic pen,
                      input logic pb, input logic sb);
    bit_time(sel, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(sel, d[i]);
    if (pen) bit_time(sel, pb);
    bit_time(sel, sb);
    drv(sel, 1'b1);
  endtask

  task automatic pop(input int sel);
    if (sel == 0) b0.rd_en = 1'b1; else b1.rd_en = 1'b1;
    @(negedge clk);
    b0.rd_en = 1'b0;
    b1.rd_en = 1'b0;
  endtask

  task automatic clr();
    b0.clr_err = 1'b1;
    b1.clr_err = 1'b1;
    @(negedge clk);
    b0.clr_err = 1'b0;
    b1.clr_err = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    vecs[1] = '{0, 8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    vecs[2] = '{0, 8'h81, 1'b0, 1'b0, 0, 1'b0, 1'b1};
    vecs[3] = '{1, 8'h03, 1'b0, 1'b1, 1, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h03, 1'b1, 1'b1, 0, 1'b1, 1'b0};
    vecs[5] = '{1, 8'h80, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h80, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[7] = '{1, 8'h07, 1'b1, 1'b0, 0, 1'b0, 1'b1};

    b0.rd_en = 1'b0; b0.clr_err = 1'b0;
    b1.rd_en = 1'b0; b1.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty",   int'(b0.empty), 1);
    chk("rst_full",    int'(b0.full), 0);
    chk("rst_count",   int'(b0.count), 0);
    chk("rst_rd_data", int'(b0.rd_data), 0);
    chk("rst_flags",   int'({b0.frame_err, b0.parity_err, b0.overrun}), 0);
    chk("rst_flags1",  int'({b1.frame_err, b1.parity_err, b1.overrun}), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 latency: empty still high in cycle 153, low in cycle 154.
    fork
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (155) @(negedge clk);
        chk("a5_empty_c153", int'(b0.empty), 1);
        @(negedge clk);
        chk("a5_empty_c154", int'(b0.empty), 0);
        chk("a5_rd_data", int'(b0.rd_data), 8'hA5);
        chk("a5_count", int'(b0.count), 1);
      end
    join
    pop(0);
    chk("a5_pop_empty", int'(b0.empty), 1);

    for (int v = 0; v < 8; v++) begin
      clr();
      send(vecs[v].sel, vecs[v].d, vecs[v].sel == 1, vecs[v].pb, vecs[v].sb);
      repeat (40) @(negedge clk);
      if (vecs[v].sel == 0) begin
        chk($sformatf("v%0d_count", v), int'(b0.count), vecs[v].push);
        chk($sformatf("v%0d_data", v), int'(b0.rd_data), vecs[v].push != 0 ? int'(vecs[v].d) : 0);
        chk($sformatf("v%0d_perr", v), int'(b0.parity_err), int'(vecs[v].perr));
        chk($sformatf("v%0d_ferr", v), int'(b0.frame_err), int'(vecs[v].ferr));
      end else begin
        chk($sformatf("v%0d_count", v), int'(b1.count), vecs[v].push);
        chk($sformatf("v%0d_data", v), int'(b1.rd_data), vecs[v].push != 0 ? int'(vecs[v].d) : 0);
        chk($sformatf("v%0d_perr", v), int'(b1.parity_err), int'(vecs[v].perr));
        chk($sformatf("v%0d_ferr", v), int'(b1.frame_err), int'(vecs[v].ferr));
      end
      if (vecs[v].push != 0) pop(vecs[v].sel);
    end

    // Parity error then clear.
    clr();
    send(1, 8'h03, 1'b1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("par_err_set", int'(b1.parity_err), 1);
    chk("par_no_push", int'(b1.count), 0);
    clr();
    chk("par_err_clr", int'(b1.parity_err), 0);

    // Stop bit low, line held low for 40 bit times: one frame error only.
    bit_time(0, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_time(0, 1'b0);
    chk("brk_ferr", int'(b0.frame_err), 1);
    clr();
    for (int i = 0; i < 37; i++) bit_time(0, 1'b0);
    chk("brk_single_ferr", int'(b0.frame_err), 0);
    chk("brk_no_push", int'(b0.count), 0);
    drv(0, 1'b1);
    repeat (32) @(negedge clk);

    // 4-cycle low glitch on idle line.
    drv(0, 1'b0);
    repeat (4) @(negedge clk);
    drv(0, 1'b1);
    repeat (48) @(negedge clk);
    chk("glitch_count", int'(b0.count), 0);
    chk("glitch_flags", int'({b0.frame_err, b0.parity_err, b0.overrun}), 0);
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("after_5a_data", int'(b0.rd_data), 8'h5A);
    chk("after_5a_count", int'(b0.count), 1);
    pop(0);

    // Five back-to-back frames into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("ovr_full", int'(b0.full), 1);
    chk("ovr_count", int'(b0.count), 4);
    chk("ovr_flag", int'(b0.overrun), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_rd%0d", i), int'(b0.rd_data), i);
      pop(0);
    end
    chk("ovr_drained", int'(b0.empty), 1);

    // Reset mid data bit 3 of 0xFF with an entry and overrun pending.
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("pre_rst_count", int'(b0.count), 1);
    bit_time(0, 1'b0);
    for (int i = 0; i < 3; i++) bit_time(0, 1'b1);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_empty", int'(b0.empty), 1);
    chk("mid_rst_count", int'(b0.count), 0);
    chk("mid_rst_data", int'(b0.rd_data), 0);
    chk("mid_rst_flags", int'({b0.frame_err, b0.parity_err, b0.overrun}), 0);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_idle", int'(b0.count), 0);
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("post_rst_data", int'(b0.rd_data), 8'h3C);
    chk("post_rst_count", int'(b0.count), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO, sitting between the board `uart_rx` pin and the core's memory-mapped peripheral bus. It generalises the fixed 8N1 receive path: configurable bit period, data width, parity mode and buffer depth, plus majority-vote sampling, false-start rejection and sticky error flags. The core drains it with a first-word-fall-through read port.

## Interface
- `CLK_DIV`, 16: clock cycles per bit; legal range ≥ 8.
- `DATA_BITS`, 8: data bits per frame; legal range 5–8.
- `PARITY`, 0: parity mode; 0 none, 1 even, 2 odd.
- `FIFO_DEPTH`, 8: receive entries; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `uart_rx`  in  1  serial line; asynchronous, idle high.
- `rd_en`  in  1  pop FIFO head; ignored when `empty`.
- `clr_err`  in  1  clear all sticky error flags.
- `rd_data`  out  DATA_BITS  FIFO head; valid when `!empty`.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(FIFO_DEPTH)+1  entries held.
- `frame_err`  out  1  sticky; stop bit sampled low.
- `parity_err`  out  1  sticky; parity mismatch.
- `overrun`  out  1  sticky; frame completed while FIFO full.

## Operation
- Reset values: `empty`=1, `full`=0, `count`=0, `rd_data`=0, all error flags 0, FSM in IDLE, synchroniser flops 1.
- `uart_rx` passes through a 2-flop synchroniser; all logic uses the synchronised signal `rxs`.
- Bit counter `cnt` runs 0..CLK_DIV-1 and wraps; HALF = CLK_DIV/2. Each bit value is the majority of `rxs` at `cnt` = HALF-1, HALF, HALF+1; the decision is taken at HALF+1.
- FSM states:
  - IDLE: `rxs`=0 → START, `cnt`=0.
  - START: if the voted value is 1 (false start) → IDLE; otherwise continue to DATA when `cnt` wraps.
  - DATA: shift in LSB first. After DATA_BITS bits → PARITY if PARITY≠0, else STOP.
  - PARITY: compare the voted bit with the computed parity. A mismatch marks the frame bad with a parity error. → STOP.
  - STOP: at the decision point:
    - voted 1 and frame good → push to FIFO, go to IDLE.
    - voted 0 → set `frame_err`, discard the frame, go to BREAK.
    - parity error → set `parity_err`, discard the frame, go to IDLE.
  - BREAK: wait for `rxs`=1, then → IDLE. A held-low line yields exactly one `frame_err`.
- STOP returns to IDLE at the decision point, not at the end of the bit, so back-to-back frames are received.
- Push when the FIFO is full: frame dropped, `overrun` set, contents unchanged.
- Push and pop in the same cycle while full: the pop takes effect first and the push is accepted; no overrun.
- Push and pop in the same cycle while empty: the push is accepted and the pop is ignored; `count`=1.
- `clr_err` clears the flags on the next edge. If an error event occurs in the same cycle as `clr_err`, the flag ends set.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. `full`/`empty` derive from `count`.

## Timing
- Cycle 0 is the first cycle `rxs`=0, which is 2 cycles after the pin edge.
- Data bit k is decided at cycle (1+k)·CLK_DIV + HALF+1.
- Stop bit is decided at cycle (1+DATA_BITS+P)·CLK_DIV + HALF+1, where P=1 if parity is enabled, else 0.
- `empty` deasserts and `rd_data` is valid one cycle after the stop decision.
- `rd_en` pop: `rd_data`, `count` and `empty` update on the same edge; the next head is visible the following cycle.
- Error flags assert one cycle after the decision point.
- Reset asserted mid-frame: FSM, FIFO and flags return to reset values immediately. After release, reception restarts only on a new falling edge seen from IDLE.

## Structure
- Shared package `uart_pkg`:
  - parity mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
  - FSM state encodings IDLE, START, DATA, PARITY, STOP, BREAK.
  - the majority-vote function.
- Sub-module `sync_fifo`: parametrised width and depth, FWFT, with `count`/`full`/`empty`. It is reusable by the future TX path.
- The top level holds the synchroniser, bit counter, FSM, shift register and error flags.

## Test plan
- Frame 0xA5, CLK_DIV=16, 8N1 → `rd_data`=0xA5, `empty` falls at cycle 9·16+9+1 after the synchronised edge, `count`=1.
- PARITY=1, send 0x03 with parity bit 1 → no push, `parity_err`=1. Then `clr_err` → 0.
- Stop bit driven 0, line held low for 40 bit times → exactly one `frame_err`, no push. Line high then 0x5A → 0x5A received.
- Low glitch of 4 cycles on an idle line → no push, no error flags, FSM back to IDLE.
- FIFO_DEPTH=4, 5 back-to-back frames 0x01..0x05, no reads → `full`=1, `overrun`=1. Reads return 0x01..0x04, then `empty`=1.
- `rst` pulsed low during data bit 3 of 0xFF → all outputs at reset values. The next frame 0x3C is received correctly.
